// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush performance counters).
package pipeline_hazard_controller_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int unsigned MDU_LATENCY_DEFAULT = 32;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipeline_hazard_controller_if;

  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic [4:0] rd_EX;
  logic       mem_read_EX;
  logic       mdu_op_EX;
  logic [4:0] rd_M;
  logic       regwrite_M;
  logic [4:0] rd_WB;
  logic       regwrite_WB;
  logic       redirect_EX;
  logic [1:0] ForwardA;
  logic [1:0] ForwardB;
  logic       stall_IF;
  logic       stall_ID;
  logic       stall_EX;
  logic       flush_ID;
  logic       mdu_start;
  logic       mdu_busy;

  modport master (
    output rs1_ID, rs2_ID, rd_EX, mem_read_EX, mdu_op_EX,
           rd_M, regwrite_M, rd_WB, regwrite_WB, redirect_EX,
    input  ForwardA, ForwardB, stall_IF, stall_ID, stall_EX,
           flush_ID, mdu_start, mdu_busy
  );

  modport slave (
    input  rs1_ID, rs2_ID, rd_EX, mem_read_EX, mdu_op_EX,
           rd_M, regwrite_M, rd_WB, regwrite_WB, redirect_EX,
    output ForwardA, ForwardB, stall_IF, stall_ID, stall_EX,
           flush_ID, mdu_start, mdu_busy
  );

endinterface

// File: rtl/pipeline_hazard_controller_forward_select.sv
// Forwarding mux select for one source operand; MEM result beats WB result.
module forward_select
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [4:0] rd_M,
  input  logic       regwrite_M,
  input  logic [4:0] rd_WB,
  input  logic       regwrite_WB,
  output logic [1:0] fwd
);

  // Pick the youngest in-flight producer of rs; x0 is never forwarded.
  always_comb begin
    fwd = FWD_NONE;
    if (regwrite_M && (rd_M != '0) && (rd_M == rs)) begin
      fwd = FWD_MEM;
    end else if (regwrite_WB && (rd_WB != '0) && (rd_WB == rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Central hazard controller: forwarding, load-use bubble, branch flush, MDU hold.
// Optional feature macro: HAZARD_PERF_CNT_EN adds stall_cycles/flush_count outputs.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned MDU_LATENCY = MDU_LATENCY_DEFAULT,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  pipeline_hazard_controller_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                  stall_cycles,
  output logic [31:0]                  flush_count
`endif
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_next;
  logic               load_use;
  logic               stall_if;
  logic               stall_id;
  logic               stall_ex;
  logic               flush_id;
  logic               start;
  logic               busy;

  forward_select u_fwd_a (
    .rs          (hz.rs1_ID),
    .rd_M        (hz.rd_M),
    .regwrite_M  (hz.regwrite_M),
    .rd_WB       (hz.rd_WB),
    .regwrite_WB (hz.regwrite_WB),
    .fwd         (hz.ForwardA)
  );

  forward_select u_fwd_b (
    .rs          (hz.rs2_ID),
    .rd_M        (hz.rd_M),
    .regwrite_M  (hz.regwrite_M),
    .rd_WB       (hz.rd_WB),
    .regwrite_WB (hz.regwrite_WB),
    .fwd         (hz.ForwardB)
  );

  assign load_use = hz.mem_read_EX && (hz.rd_EX != '0) &&
                    ((hz.rd_EX == hz.rs1_ID) || (hz.rd_EX == hz.rs2_ID));

  // State and MDU down-counter registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: an MDU op only launches when no redirect or load-use outranks it.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      RUN: begin
        if (!hz.redirect_EX && !load_use && hz.mdu_op_EX) begin
          state_next = MDU_WAIT;
          cnt_next   = CNT_W'(MDU_LATENCY - 1);
        end
      end
      MDU_WAIT: begin
        cnt_next = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_next = RUN;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs: redirect > load-use > MDU start in RUN; full hold while MDU_WAIT.
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    case (state)
      RUN: begin
        if (hz.redirect_EX) begin
          flush_id = 1'b1;
          stall_ex = 1'b1;
        end else if (load_use) begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          stall_ex = 1'b1;
        end else if (hz.mdu_op_EX) begin
          start    = 1'b1;
          stall_if = 1'b1;
          stall_id = 1'b1;
        end
      end
      MDU_WAIT: begin
        busy     = 1'b1;
        stall_if = 1'b1;
        stall_id = 1'b1;
        stall_ex = 1'b1;
      end
      default: ;
    endcase
  end

  assign hz.stall_IF  = stall_if;
  assign hz.stall_ID  = stall_id;
  assign hz.stall_EX  = stall_ex;
  assign hz.flush_ID  = flush_id;
  assign hz.mdu_start = start;
  assign hz.mdu_busy  = busy;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating stall-cycle and flush event counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_if && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (flush_id && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller (MDU_LATENCY=4).
// Expected vector layout: {ForwardA, ForwardB, stall_IF, stall_ID, stall_EX, flush_ID, mdu_start, mdu_busy}.
module tb_pipeline_hazard_controller;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  pipeline_hazard_controller_if hz ();

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipeline_hazard_controller #(
    .MDU_LATENCY (4),
    .CNT_W       (8)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .hz      (hz)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  always #5 CLK = ~CLK;

  // One cycle of stimulus, driven #1 after the rising edge; expected outputs queued.
  task automatic cyc(input string nm, input logic rst,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rdex,
                     input logic mrd, input logic mdu,
                     input logic [4:0] rdm, input logic rwm,
                     input logic [4:0] rdwb, input logic rwwb,
                     input logic redir, input logic [9:0] e);
    exp_t item;
    @(posedge CLK);
    #1;
    RESET_N        = rst;
    hz.rs1_ID      = rs1;
    hz.rs2_ID      = rs2;
    hz.rd_EX       = rdex;
    hz.mem_read_EX = mrd;
    hz.mdu_op_EX   = mdu;
    hz.rd_M        = rdm;
    hz.regwrite_M  = rwm;
    hz.rd_WB       = rdwb;
    hz.regwrite_WB = rwwb;
    hz.redirect_EX = redir;
    item.name = nm;
    item.exp  = e;
    q.push_back(item);
  endtask

  // Monitor: every falling edge, pop the pending expectation and compare.
  initial begin
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        exp_t       e;
        logic [9:0] act;
        e   = q.pop_front();
        act = {hz.ForwardA, hz.ForwardB, hz.stall_IF, hz.stall_ID, hz.stall_EX,
               hz.flush_ID, hz.mdu_start, hz.mdu_busy};
        total++;
        if (act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    hz.rs1_ID = '0; hz.rs2_ID = '0; hz.rd_EX = '0; hz.mem_read_EX = 1'b0;
    hz.mdu_op_EX = 1'b0; hz.rd_M = '0; hz.regwrite_M = 1'b0; hz.rd_WB = '0;
    hz.regwrite_WB = 1'b0; hz.redirect_EX = 1'b0;

    //   name           rst rs1 rs2 rdEX mrd mdu rdM rwM rdWB rwWB red  expected
    cyc("reset",        0,  0,  0,  0,   0,  0,  0,  0,  0,   0,   0,   10'b00_00_000000);
    cyc("idle",         1,  0,  0,  0,   0,  0,  0,  0,  0,   0,   0,   10'b00_00_000000);
    cyc("load_use",     1,  0,  7,  7,   1,  0,  0,  0,  0,   0,   0,   10'b00_00_111000);
    cyc("load_fwd_b",   1,  0,  7,  0,   0,  0,  7,  1,  0,   0,   0,   10'b00_10_000000);
    cyc("ld_use_redir", 1,  3,  0,  3,   1,  0,  0,  0,  0,   0,   1,   10'b00_00_001100);
    cyc("after_flush",  1,  0,  0,  0,   0,  0,  0,  0,  0,   0,   0,   10'b00_00_000000);
`ifdef HAZARD_PERF_CNT_EN
    total++;
    if (stall_cycles !== 32'd1) begin
      bad++;
      $display("FAIL stall_cycles: got %0d expected 1", stall_cycles);
    end
    total++;
    if (flush_count !== 32'd1) begin
      bad++;
      $display("FAIL flush_count: got %0d expected 1", flush_count);
    end
`endif
    cyc("fwd_a_mem",    1,  5,  0,  0,   0,  0,  5,  1,  5,   1,   0,   10'b10_00_000000);
    cyc("fwd_a_wb",     1,  5,  0,  0,   0,  0,  5,  0,  5,   1,   0,   10'b01_00_000000);
    cyc("fwd_a_x0",     1,  5,  0,  0,   0,  0,  0,  1,  0,   1,   0,   10'b00_00_000000);
    cyc("fwd_ab_mix",   1,  2,  9,  0,   0,  0,  2,  1,  9,   1,   0,   10'b10_01_000000);
    cyc("rs_x0_no_fwd", 1,  0,  0,  0,   1,  0,  0,  1,  0,   1,   0,   10'b00_00_000000);
    cyc("mdu_start",    1,  0,  0,  0,   0,  1,  0,  0,  0,   0,   0,   10'b00_00_110010);
    cyc("mdu_wait1",    1,  0,  0,  0,   0,  1,  0,  0,  0,   0,   1,   10'b00_00_111001);
    cyc("mdu_wait2",    1,  4,  0,  4,   1,  1,  0,  0,  0,   0,   0,   10'b00_00_111001);
    cyc("mdu_wait3",    1,  0,  0,  0,   0,  1,  0,  0,  0,   0,   0,   10'b00_00_111001);
    cyc("mdu_done",     1,  0,  0,  0,   0,  0,  0,  0,  0,   0,   0,   10'b00_00_000000);
    cyc("mdu2_start",   1,  0,  0,  0,   0,  1,  0,  0,  0,   0,   0,   10'b00_00_110010);
    cyc("mdu2_wait",    1,  0,  0,  0,   0,  1,  0,  0,  0,   0,   0,   10'b00_00_111001);
    cyc("reset_mid",    0,  0,  0,  0,   0,  0,  0,  0,  0,   0,   0,   10'b00_00_000000);
    cyc("post_reset",   1,  0,  0,  0,   0,  0,  0,  0,  0,   0,   0,   10'b00_00_000000);
    cyc("run_load_use", 1,  6,  0,  6,   1,  0,  0,  0,  0,   0,   0,   10'b00_00_111000);
    cyc("tail",         1,  0,  0,  0,   0,  0,  0,  0,  0,   0,   0,   10'b00_00_000000);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    @(posedge CLK);
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
